// File: rtl/vga_layer_compositor.sv
// VGA timing generator with a two-stage priority compositor for N colour layers,
// a border and a background. RGB and syncs leave the block mutually aligned.
module vga_layer_compositor #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int NUM_LAYERS = 8,
    parameter int BORDER_W   = 4,
    localparam int XW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int YW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP),
    localparam int CW3 = 3 * COLOR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_en,
    input  logic [NUM_LAYERS-1:0]     layer_on,
    input  logic [NUM_LAYERS*CW3-1:0] layer_rgb,
    input  logic [CW3-1:0]            bg_rgb,
    input  logic [CW3-1:0]            border_rgb,
    input  logic                      border_en,
    output logic [XW-1:0]             CounterX,
    output logic [YW-1:0]             CounterY,
    output logic                      inDisplayArea,
    output logic                      frame_start,
    output logic                      vga_h_sync,
    output logic                      vga_v_sync,
    output logic [COLOR_W-1:0]        vga_R,
    output logic [COLOR_W-1:0]        vga_G,
    output logic [COLOR_W-1:0]        vga_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] X_BRD_LO   = XW'(BORDER_W);
    localparam logic [XW-1:0] X_BRD_HI   = XW'(H_ACTIVE - BORDER_W);

    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] Y_BRD_LO   = YW'(BORDER_W);
    localparam logic [YW-1:0] Y_BRD_HI   = YW'(V_ACTIVE - BORDER_W);

    logic           x_last;
    logic           y_last;
    logic           hs_raw;
    logic           vs_raw;
    logic           in_border;
    logic [CW3-1:0] win_rgb;

    logic [CW3-1:0] s1_rgb;
    logic           s1_hs;
    logic           s1_vs;
    logic           s1_de;

    assign x_last        = (CounterX == X_LAST);
    assign y_last        = (CounterY == Y_LAST);
    assign inDisplayArea = (CounterX < X_ACT) && (CounterY < Y_ACT);
    assign hs_raw        = (CounterX >= X_HS_START) && (CounterX < X_HS_END);
    assign vs_raw        = (CounterY >= Y_VS_START) && (CounterY < Y_VS_END);
    assign in_border     = (CounterX < X_BRD_LO) || (CounterX >= X_BRD_HI) ||
                           (CounterY < Y_BRD_LO) || (CounterY >= Y_BRD_HI);

    // Walk from the highest index down so the lowest-index hit overwrites last.
    always_comb begin
        win_rgb = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
                win_rgb = layer_rgb[i*CW3 +: CW3];
            end
        end
        if (border_en && inDisplayArea && in_border) begin
            win_rgb = border_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CounterX    <= '0;
            CounterY    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && x_last && y_last;
            if (pix_en) begin
                if (x_last) begin
                    CounterX <= '0;
                    CounterY <= y_last ? '0 : CounterY + 1'b1;
                end else begin
                    CounterX <= CounterX + 1'b1;
                end
            end
        end
    end

    // Stage 1: winning colour plus timing flags delayed to match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rgb <= '0;
            s1_hs  <= ~SYNC_POL;
            s1_vs  <= ~SYNC_POL;
            s1_de  <= 1'b0;
        end else if (pix_en) begin
            s1_rgb <= win_rgb;
            s1_hs  <= hs_raw ? SYNC_POL : ~SYNC_POL;
            s1_vs  <= vs_raw ? SYNC_POL : ~SYNC_POL;
            s1_de  <= inDisplayArea;
        end
    end

    // Stage 2: blank outside the active area so porches and syncs carry black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_R      <= '0;
            vga_G      <= '0;
            vga_B      <= '0;
            vga_h_sync <= ~SYNC_POL;
            vga_v_sync <= ~SYNC_POL;
        end else if (pix_en) begin
            vga_R      <= s1_de ? s1_rgb[CW3-1 -: COLOR_W]       : '0;
            vga_G      <= s1_de ? s1_rgb[2*COLOR_W-1 -: COLOR_W] : '0;
            vga_B      <= s1_de ? s1_rgb[COLOR_W-1:0]            : '0;
            vga_h_sync <= s1_hs;
            vga_v_sync <= s1_vs;
        end
    end

endmodule
